alu_cmd_issuer: RTL and testbench
=================================

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: ALU operand width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum number of WAIT cycles for alu_result_valid.
REQ-003 SHALL have port: clk  input  1  single clock; all flops on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: cmd_valid  input  1  command offered.
REQ-006 SHALL have port: cmd_ready  output  1  issuer can accept a command.
REQ-007 SHALL have port: cmd_A, cmd_B  input  DATA_WIDTH  command operands.
REQ-008 SHALL have port: cmd_function  input  4  ALU opcode.
REQ-009 SHALL have port: alu_A, alu_B  output  DATA_WIDTH  operands driven to the ALU.
REQ-010 SHALL have port: alu_function  output  4  opcode driven to the ALU.
REQ-011 SHALL have port: alu_enable  output  1  ALU operation strobe.
REQ-012 SHALL have port: alu_result_valid  input  1  ALU result strobe.
REQ-013 SHALL have port: alu_result  input  2*DATA_WIDTH  ALU result.
REQ-014 SHALL have port: rsp_valid  output  1  response available.
REQ-015 SHALL have port: rsp_ready  input  1  consumer accepts the response.
REQ-016 SHALL have port: rsp_result  output  2*DATA_WIDTH  captured result.
REQ-017 SHALL have port: rsp_error  output  1  response is an error.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-019 SHALL drive cmd_ready = (state == IDLE); a command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-020 SHALL, on acceptance, register cmd_A, cmd_B and cmd_function, and hold alu_A, alu_B and alu_function stable from ISSUE through the end of WAIT.
REQ-021 SHALL treat the legal opcodes as 4'b0000-4'b0101 (add, sub, mul, div, and, or).
REQ-022 SHALL, for an illegal opcode, or for div (4'b0011) with cmd_B == 0, go from IDLE directly to RESP with rsp_error = 1 and rsp_result = 0, and never assert alu_enable.
REQ-023 SHALL, for a legal command, go from IDLE to ISSUE; alu_enable SHALL be 1 for exactly the one ISSUE cycle, and the next state is WAIT.
REQ-024 SHALL run a WAIT counter that clears on entry to WAIT and increments every WAIT cycle.
REQ-025 SHALL sample alu_result_valid only in WAIT and ignore it in every other state.
REQ-026 SHALL, when alu_result_valid = 1 in WAIT, capture alu_result into rsp_result, set rsp_error = 0 and go to RESP.
REQ-027 SHALL, when the WAIT counter reaches TIMEOUT_CYCLES without alu_result_valid, go to RESP with rsp_error = 1 and rsp_result = 0.
REQ-028 SHALL give alu_result_valid priority when it coincides with the timeout cycle: the result is captured and there is no error.
REQ-029 SHALL hold rsp_valid = 1 in RESP, with rsp_result and rsp_error stable, until rsp_ready = 1; the next state is then IDLE.
REQ-030 SHALL have minimum latency from command acceptance to rsp_valid of ISSUE + 1 WAIT cycle + 1, i.e. rsp_valid rises on the edge after alu_result_valid is sampled.
REQ-031 SHALL allow only one command in flight; no new command is accepted before the response handshake completes.

Reset
REQ-032 SHALL, while reset = 0, force state to IDLE and clear alu_A, alu_B, alu_function, alu_enable, rsp_valid, rsp_result, rsp_error and the WAIT counter to 0.
REQ-033 SHALL show cmd_ready = 1 while in reset, but SHALL accept no command while reset = 0.
REQ-034 SHALL, on reset in mid-operation (ISSUE, WAIT or RESP), abandon the command with no response, and ignore any later alu_result_valid until a new command is issued.

Structure
REQ-035 SHALL take the ALU opcode constants (ADD..OR, last legal code) and the FSM state encodings from the shared package alu_defs, which is also used by the ALU.
REQ-036 SHALL contain one sub-module, alu_timeout_counter (inputs: clear, count enable, limit; output: expired).

Verification
REQ-037 SHALL verify add: A=0x54, B=0x2A, fn=0000 -> one alu_enable pulse, then rsp_result=0x007E, rsp_error=0.
REQ-038 SHALL verify mul: A=0x54, B=0x2A, fn=0010 -> rsp_result=0x0DC8, rsp_error=0.
REQ-039 SHALL verify rejection: A=0x54, B=0x00, fn=0011, then fn=1010 -> alu_enable never 1; rsp_error=1, rsp_result=0 for each.
REQ-040 SHALL verify timeout: ALU model never asserts valid -> rsp_valid after exactly 15 WAIT cycles with rsp_error=1; valid arriving on cycle 15 -> no error.
REQ-041 SHALL verify backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_result and rsp_error held, cmd_ready=0; accept -> IDLE next cycle.
REQ-042 SHALL verify reset in WAIT: reset=0 for one cycle -> all outputs 0 and no response; next command (A=0xF4, B=0x2C, fn=0101) -> rsp_result=0x00FC.

Source files
------------

// File: rtl/alu_defs.sv
// Shared ALU definitions: opcode constants and issuer FSM state encoding.
// Used by both the command issuer and the ALU itself.
package alu_defs;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD        = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB        = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_MUL        = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_DIV        = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_AND        = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_OR         = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_LAST_LEGAL = ALU_OR;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic opcode_legal(input logic [ALU_OP_W-1:0] fn);
        return (fn <= ALU_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_timeout.sv
// WAIT-state cycle counter; flags the cycle in which the wait budget runs out.
module alu_timeout_counter #(
    parameter int unsigned CNT_W = 4
)(
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_count_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // r_count holds cycles already spent, so the limit-th counting cycle is the last one
    assign o_expired = i_count_en && (r_count == (i_limit - CNT_W'(1)));

endmodule

// File: rtl/alu_cmd_issuer.sv
// Single-outstanding ALU command issuer: validates a command, strobes the ALU,
// waits (bounded) for its result and holds the response until consumed.
module alu_cmd_issuer
    import alu_defs::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 15
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_A,
    input  logic [DATA_WIDTH-1:0]   cmd_B,
    input  logic [ALU_OP_W-1:0]     cmd_function,
    output logic [DATA_WIDTH-1:0]   alu_A,
    output logic [DATA_WIDTH-1:0]   alu_B,
    output logic [ALU_OP_W-1:0]     alu_function,
    output logic                    alu_enable,
    input  logic                    alu_result_valid,
    input  logic [2*DATA_WIDTH-1:0] alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_result,
    output logic                    rsp_error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t r_state;
    logic   w_cmd_ok;
    logic   w_clear;
    logic   w_count_en;
    logic   w_expired;

    assign cmd_ready  = (r_state == ST_IDLE);
    assign w_cmd_ok   = opcode_legal(cmd_function) &&
                        !((cmd_function == ALU_DIV) && (cmd_B == '0));
    assign w_clear    = (r_state == ST_ISSUE);
    assign w_count_en = (r_state == ST_WAIT);

    alu_timeout_counter #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk        (clk),
        .i_rst_n    (reset),
        .i_clear    (w_clear),
        .i_count_en (w_count_en),
        .i_limit    (CNT_W'(TIMEOUT_CYCLES)),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            alu_A        <= '0;
            alu_B        <= '0;
            alu_function <= '0;
            alu_enable   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_error    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        alu_A        <= cmd_A;
                        alu_B        <= cmd_B;
                        alu_function <= cmd_function;
                        if (w_cmd_ok) begin
                            alu_enable <= 1'b1;
                            r_state    <= ST_ISSUE;
                        end else begin
                            // Rejected commands never reach the ALU
                            rsp_valid  <= 1'b1;
                            rsp_error  <= 1'b1;
                            rsp_result <= '0;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    alu_enable <= 1'b0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result in the final budgeted cycle still wins over the timeout
                    if (alu_result_valid) begin
                        rsp_valid  <= 1'b1;
                        rsp_error  <= 1'b0;
                        rsp_result <= alu_result;
                        r_state    <= ST_RESP;
                    end else if (w_expired) begin
                        rsp_valid  <= 1'b1;
                        rsp_error  <= 1'b1;
                        rsp_result <= '0;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed self-checking bench for alu_cmd_issuer with a small behavioural ALU.
module tb_alu_cmd_issuer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_A;
    logic [7:0]  cmd_B;
    logic [3:0]  cmd_function;
    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [3:0]  alu_function;
    logic        alu_enable;
    logic        alu_result_valid;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_error;

    int n_checks = 0;
    int n_fail   = 0;

    alu_cmd_issuer #(
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_A            (cmd_A),
        .cmd_B            (cmd_B),
        .cmd_function     (cmd_function),
        .alu_A            (alu_A),
        .alu_B            (alu_B),
        .alu_function     (alu_function),
        .alu_enable       (alu_enable),
        .alu_result_valid (alu_result_valid),
        .alu_result       (alu_result),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_result       (rsp_result),
        .rsp_error        (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] fn);
        case (fn)
            4'b0000: return {8'h00, a} + {8'h00, b};
            4'b0001: return {8'h00, a} - {8'h00, b};
            4'b0010: return {8'h00, a} * {8'h00, b};
            4'b0011: return (b == 8'h00) ? 16'h0000 : {8'h00, a / b};
            4'b0100: return {8'h00, a & b};
            4'b0101: return {8'h00, a | b};
            default: return 16'hDEAD;
        endcase
    endfunction

    // Offers one command and plays the ALU; valid is returned in WAIT cycle lat (0 = never).
    task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn,
                             input int lat, output int n_en, output int n_wait, output bit got);
        n_en = 0; n_wait = 0; got = 1'b0;
        cmd_valid = 1'b1; cmd_A = a; cmd_B = b; cmd_function = fn;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (alu_enable) n_en++;
            else begin
                n_wait++;
                if (n_wait == lat) begin
                    alu_result_valid = 1'b1;
                    alu_result = alu_model(alu_A, alu_B, alu_function);
                end
            end
            tick();
            alu_result_valid = 1'b0;
            alu_result = 16'hBEEF;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_idle: rsp_valid=%b cmd_ready=%b, required 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cmd_valid = 1'b1; cmd_A = 8'h11; cmd_B = 8'h22; cmd_function = 4'b0000;
        #1;
        repeat (3) tick();
        n_checks++;
        if ({alu_A, alu_B, alu_function, alu_enable, rsp_valid, rsp_result, rsp_error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: alu_A=%h alu_B=%h fn=%h en=%b rv=%b res=%h err=%b, required all 0",
                     alu_A, alu_B, alu_function, alu_enable, rsp_valid, rsp_result, rsp_error);
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
        end
        cmd_valid = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++;
        if (alu_enable !== 1'b0 || rsp_valid !== 1'b0 || alu_A !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_no_accept: en=%b rv=%b alu_A=%h, required 0/0/00", alu_enable, rsp_valid, alu_A);
        end
    endtask

    task automatic test_add();
        int n_en, n_wait; bit got;
        drive_cmd(8'h54, 8'h2A, 4'b0000, 1, n_en, n_wait, got);
        n_checks++;
        if (!got || n_en != 1 || n_wait != 1) begin
            n_fail++;
            $display("FAIL add_timing: got=%b en_pulses=%0d wait_cycles=%0d, required 1/1/1", got, n_en, n_wait);
        end
        n_checks++;
        if (rsp_result !== 16'h007E || rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL add_result: res=%h err=%b, required 007e/0", rsp_result, rsp_error);
        end
        finish_rsp();
    endtask

    task automatic test_mul();
        int n_en, n_wait; bit got;
        drive_cmd(8'h54, 8'h2A, 4'b0010, 3, n_en, n_wait, got);
        n_checks++;
        if (!got || n_en != 1 || n_wait != 3) begin
            n_fail++;
            $display("FAIL mul_timing: got=%b en_pulses=%0d wait_cycles=%0d, required 1/1/3", got, n_en, n_wait);
        end
        n_checks++;
        if (rsp_result !== 16'h0DC8 || rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_result: res=%h err=%b, required 0dc8/0", rsp_result, rsp_error);
        end
        finish_rsp();
    endtask

    task automatic test_reject();
        int n_en, n_wait; bit got;
        logic [3:0] fns [2];
        fns[0] = 4'b0011;
        fns[1] = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            drive_cmd(8'h54, 8'h00, fns[i], 1, n_en, n_wait, got);
            n_checks++;
            if (!got || n_en != 0 || n_wait != 0) begin
                n_fail++;
                $display("FAIL reject_path fn=%b: got=%b en_pulses=%0d wait_cycles=%0d, required 1/0/0",
                         fns[i], got, n_en, n_wait);
            end
            n_checks++;
            if (rsp_result !== 16'h0000 || rsp_error !== 1'b1) begin
                n_fail++;
                $display("FAIL reject_result fn=%b: res=%h err=%b, required 0000/1", fns[i], rsp_result, rsp_error);
            end
            finish_rsp();
        end
    endtask

    task automatic test_timeout();
        int n_en, n_wait; bit got;
        drive_cmd(8'h54, 8'h2A, 4'b0000, 0, n_en, n_wait, got);
        n_checks++;
        if (!got || n_wait != 15 || rsp_error !== 1'b1 || rsp_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL timeout_expire: got=%b wait_cycles=%0d err=%b res=%h, required 1/15/1/0000",
                     got, n_wait, rsp_error, rsp_result);
        end
        finish_rsp();
        drive_cmd(8'h54, 8'h2A, 4'b0001, 15, n_en, n_wait, got);
        n_checks++;
        if (!got || n_wait != 15 || rsp_error !== 1'b0 || rsp_result !== 16'h002A) begin
            n_fail++;
            $display("FAIL timeout_last_cycle: got=%b wait_cycles=%0d err=%b res=%h, required 1/15/0/002a",
                     got, n_wait, rsp_error, rsp_result);
        end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int n_en, n_wait; bit got;
        int bad;
        drive_cmd(8'h54, 8'h2A, 4'b0000, 2, n_en, n_wait, got);
        bad = 0;
        cmd_valid = 1'b1; cmd_A = 8'h01; cmd_B = 8'h02; cmd_function = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_result !== 16'h007E || rsp_error !== 1'b0 ||
                cmd_ready !== 1'b0 || alu_enable !== 1'b0) bad++;
            tick();
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!got || bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: got=%b bad_cycles=%0d rv=%b res=%h err=%b rdy=%b, required 1/0/1/007e/0/0",
                     got, bad, rsp_valid, rsp_result, rsp_error, cmd_ready);
        end
        finish_rsp();
        tick();
        n_checks++;
        if (alu_enable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_no_stale_cmd: en=%b rv=%b rdy=%b, required 0/0/1", alu_enable, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        int n_en, n_wait; bit got;
        cmd_valid = 1'b1; cmd_A = 8'h54; cmd_B = 8'h2A; cmd_function = 4'b0000;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({alu_A, alu_B, alu_function, alu_enable, rsp_valid, rsp_result, rsp_error} !== '0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait_outputs: alu_A=%h alu_B=%h fn=%h en=%b rv=%b res=%h err=%b rdy=%b, required 0s and rdy=1",
                     alu_A, alu_B, alu_function, alu_enable, rsp_valid, rsp_result, rsp_error, cmd_ready);
        end
        tick();
        reset = 1'b1;
        alu_result_valid = 1'b1; alu_result = 16'h1234;
        tick();
        alu_result_valid = 1'b0;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_wait_ignore_valid: rv=%b res=%h, required 0/0000", rsp_valid, rsp_result);
        end
        drive_cmd(8'hF4, 8'h2C, 4'b0101, 2, n_en, n_wait, got);
        n_checks++;
        if (!got || rsp_result !== 16'h00FC || rsp_error !== 1'b0 || n_en != 1) begin
            n_fail++;
            $display("FAIL reset_wait_next_cmd: got=%b res=%h err=%b en_pulses=%0d, required 1/00fc/0/1",
                     got, rsp_result, rsp_error, n_en);
        end
        finish_rsp();
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_A = '0; cmd_B = '0; cmd_function = '0;
        alu_result_valid = 1'b0; alu_result = '0; rsp_ready = 1'b0;
        reset = 1'b1;
        test_reset();
        test_add();
        test_mul();
        test_reject();
        test_timeout();
        test_backpressure();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
